// File: rtl/cam_power_init_ctrl.sv
// Camera bring-up sequencer: timed power-down/reset pin sequence, SCCB init
// handshake with power-cycle retries, sleep/wake and fault reporting.
module cam_power_init_ctrl #(
  parameter int T_PWDN_HOLD  = 135000,
  parameter int T_RST_HOLD   = 35000,
  parameter int T_BOOT       = 540000,
  parameter int INIT_TIMEOUT = 2700000,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 22
) (
  input  logic       clk_27,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sleep_req,
  input  logic       init_done,
  input  logic       init_err,
  output logic       camera_pwnd,
  output logic       camera_rstn,
  output logic       init_start,
  output logic       cam_ready,
  output logic       fault,
  output logic [2:0] state_o,
  output logic [1:0] retry_cnt
);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_PWR_WAIT  = 3'd1,
    ST_RST_WAIT  = 3'd2,
    ST_BOOT_WAIT = 3'd3,
    ST_INIT      = 3'd4,
    ST_READY     = 3'd5,
    ST_SLEEP     = 3'd6,
    ST_FAULT     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(T_PWDN_HOLD - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(T_RST_HOLD - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(T_BOOT - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [1:0]       MAX_RETRY_V = 2'(MAX_RETRY);

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [1:0]       retry_r, retry_next_s, retry_step_s;

  // {pwnd, rstn} pin levels for a state
  function automatic logic [1:0] pins_of(input state_t st);
    case (st)
      ST_OFF, ST_PWR_WAIT, ST_FAULT: pins_of = 2'b10;
      ST_RST_WAIT:                   pins_of = 2'b00;
      ST_BOOT_WAIT, ST_INIT, ST_READY: pins_of = 2'b01;
      ST_SLEEP:                      pins_of = 2'b11;
      default:                       pins_of = 2'b10;
    endcase
  endfunction

  // Next-state, retry and delay-counter logic
  always_comb begin
    state_next_s = state_r;
    retry_step_s = retry_r;
    if (!enable) begin
      state_next_s = ST_OFF;
    end else begin
      case (state_r)
        ST_OFF: state_next_s = ST_PWR_WAIT;
        ST_PWR_WAIT: begin
          if (cnt_r == PWR_LAST) state_next_s = ST_RST_WAIT;
          else                   state_next_s = ST_PWR_WAIT;
        end
        ST_RST_WAIT: begin
          if (cnt_r == RST_LAST) state_next_s = ST_BOOT_WAIT;
          else                   state_next_s = ST_RST_WAIT;
        end
        ST_BOOT_WAIT: begin
          if (cnt_r == BOOT_LAST) state_next_s = ST_INIT;
          else                    state_next_s = ST_BOOT_WAIT;
        end
        ST_INIT: begin
          // err beats done; done beats the timeout
          if (init_err || (!init_done && (cnt_r == INIT_LAST))) begin
            if (retry_r < MAX_RETRY_V) begin
              retry_step_s = retry_r + 2'd1;
              state_next_s = ST_PWR_WAIT;
            end else begin
              retry_step_s = retry_r;
              state_next_s = ST_FAULT;
            end
          end else if (init_done) begin
            state_next_s = ST_READY;
          end else begin
            state_next_s = ST_INIT;
          end
        end
        ST_READY: begin
          if (sleep_req) state_next_s = ST_SLEEP;
          else           state_next_s = ST_READY;
        end
        ST_SLEEP: begin
          if (sleep_req) state_next_s = ST_SLEEP;
          else           state_next_s = ST_BOOT_WAIT;
        end
        ST_FAULT: state_next_s = ST_FAULT;
        default:  state_next_s = ST_OFF;
      endcase
    end

    if (state_next_s == ST_OFF) retry_next_s = 2'd0;
    else                        retry_next_s = retry_step_s;

    if (state_next_s != state_r)  cnt_next_s = {CNT_W{1'b0}};
    else if (cnt_r == CNT_MAX)    cnt_next_s = cnt_r;
    else                          cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // State, counter and registered outputs decoded from the next state
  always_ff @(posedge clk_27 or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_OFF;
      cnt_r       <= {CNT_W{1'b0}};
      retry_r     <= 2'd0;
      camera_pwnd <= 1'b1;
      camera_rstn <= 1'b0;
      init_start  <= 1'b0;
      cam_ready   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_r                    <= state_next_s;
      cnt_r                      <= cnt_next_s;
      retry_r                    <= retry_next_s;
      {camera_pwnd, camera_rstn} <= pins_of(state_next_s);
      init_start                 <= (state_next_s == ST_INIT) && (state_r != ST_INIT);
      cam_ready                  <= (state_next_s == ST_READY);
      fault                      <= (state_next_s == ST_FAULT);
    end
  end

  assign state_o   = state_r;
  assign retry_cnt = retry_r;

endmodule

// File: tb/tb_cam_power_init_ctrl.sv
// Directed bench for cam_power_init_ctrl with shortened timing parameters.
module tb_cam_power_init_ctrl;

  logic       clk_27 = 1'b0;
  logic       rst_n, enable, sleep_req, init_done, init_err;
  logic       camera_pwnd, camera_rstn, init_start, cam_ready, fault;
  logic [2:0] state_o;
  logic [1:0] retry_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_27 = ~clk_27;

  cam_power_init_ctrl #(
    .T_PWDN_HOLD(10), .T_RST_HOLD(5), .T_BOOT(8), .INIT_TIMEOUT(50),
    .MAX_RETRY(2), .CNT_W(22)
  ) dut (
    .clk_27(clk_27), .rst_n(rst_n), .enable(enable), .sleep_req(sleep_req),
    .init_done(init_done), .init_err(init_err),
    .camera_pwnd(camera_pwnd), .camera_rstn(camera_rstn),
    .init_start(init_start), .cam_ready(cam_ready), .fault(fault),
    .state_o(state_o), .retry_cnt(retry_cnt)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk_27);
  endtask

  // Expected vector: {state, pwnd, rstn, init_start, cam_ready, fault, retry}
  task automatic chk(input string tag, input logic [2:0] st, input logic start,
                     input logic [1:0] r);
    logic [1:0] pins;
    logic [9:0] exp_v, obs_v;
    case (st)
      3'd0, 3'd1, 3'd7: pins = 2'b10;
      3'd2:             pins = 2'b00;
      3'd3, 3'd4, 3'd5: pins = 2'b01;
      3'd6:             pins = 2'b11;
      default:          pins = 2'bxx;
    endcase
    exp_v = {st, pins, start, (st == 3'd5), (st == 3'd7), r};
    obs_v = {state_o, camera_pwnd, camera_rstn, init_start, cam_ready, fault, retry_cnt};
    n_cmp++;
    assert (obs_v === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs_v, exp_v);
    end
  endtask

  // Called at the first negedge in PWR_WAIT; returns at INIT with counter=1
  task automatic seq_from_pwr(input string tag, input logic [1:0] r);
    chk({tag, "_pwr0"}, 3'd1, 1'b0, r);
    step(9);  chk({tag, "_pwr9"}, 3'd1, 1'b0, r);
    step(1);  chk({tag, "_rst0"}, 3'd2, 1'b0, r);
    step(4);  chk({tag, "_rst4"}, 3'd2, 1'b0, r);
    step(1);  chk({tag, "_boot0"}, 3'd3, 1'b0, r);
    step(7);  chk({tag, "_boot7"}, 3'd3, 1'b0, r);
    step(1);  chk({tag, "_start"}, 3'd4, 1'b1, r);
    step(1);  chk({tag, "_start_end"}, 3'd4, 1'b0, r);
  endtask

  task automatic pulse_done();
    init_done = 1'b1; step(1); init_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; sleep_req = 1'b0; init_done = 1'b0; init_err = 1'b0;
    step(2);  chk("reset", 3'd0, 1'b0, 2'd0);
    rst_n = 1'b1;
    step(2);  chk("idle_off", 3'd0, 1'b0, 2'd0);

    // 1. nominal bring-up
    enable = 1'b1; step(1);
    seq_from_pwr("t1", 2'd0);
    step(18); chk("t1_init_wait", 3'd4, 1'b0, 2'd0);
    pulse_done(); chk("t1_ready", 3'd5, 1'b0, 2'd0);

    // 2. init error retry from a fresh power-up
    enable = 1'b0; step(1); chk("t2_off", 3'd0, 1'b0, 2'd0);
    enable = 1'b1; step(1);
    seq_from_pwr("t2a", 2'd0);
    init_err = 1'b1; step(1); init_err = 1'b0;
    seq_from_pwr("t2b", 2'd1);
    pulse_done(); chk("t2_ready", 3'd5, 1'b0, 2'd1);

    // 3. timeouts exhaust retries into FAULT
    enable = 1'b0; step(1); chk("t3_off", 3'd0, 1'b0, 2'd0);
    enable = 1'b1; step(1);
    seq_from_pwr("t3a", 2'd0);
    step(48); chk("t3a_last", 3'd4, 1'b0, 2'd0);
    step(1);
    seq_from_pwr("t3b", 2'd1);
    step(48); chk("t3b_last", 3'd4, 1'b0, 2'd1);
    step(1);
    seq_from_pwr("t3c", 2'd2);
    step(48); chk("t3c_last", 3'd4, 1'b0, 2'd2);
    step(1);  chk("t3_fault", 3'd7, 1'b0, 2'd2);
    step(5);  chk("t3_fault_hold", 3'd7, 1'b0, 2'd2);
    enable = 1'b0; step(1); chk("t3_off_clr", 3'd0, 1'b0, 2'd0);

    // 4. done+err together -> retry; done in timeout cycle -> READY
    enable = 1'b1; step(1);
    seq_from_pwr("t4a", 2'd0);
    init_done = 1'b1; init_err = 1'b1; step(1); init_done = 1'b0; init_err = 1'b0;
    seq_from_pwr("t4b", 2'd1);
    step(48); chk("t4_last", 3'd4, 1'b0, 2'd1);
    pulse_done(); chk("t4_ready", 3'd5, 1'b0, 2'd1);

    // 5. sleep and wake
    sleep_req = 1'b1; step(1); chk("t5_sleep", 3'd6, 1'b0, 2'd1);
    step(3);  chk("t5_sleep_hold", 3'd6, 1'b0, 2'd1);
    sleep_req = 1'b0; step(1); chk("t5_wake_boot0", 3'd3, 1'b0, 2'd1);
    step(7);  chk("t5_boot7", 3'd3, 1'b0, 2'd1);
    step(1);  chk("t5_start", 3'd4, 1'b1, 2'd1);
    step(1);  chk("t5_start_end", 3'd4, 1'b0, 2'd1);
    pulse_done(); chk("t5_ready", 3'd5, 1'b0, 2'd1);

    // 6. abort in RST_WAIT, stray init pulses ignored, async reset in BOOT_WAIT
    enable = 1'b0; step(1); chk("t6_off", 3'd0, 1'b0, 2'd0);
    enable = 1'b1; step(1); chk("t6_pwr", 3'd1, 1'b0, 2'd0);
    init_done = 1'b1; init_err = 1'b1; step(1); init_done = 1'b0; init_err = 1'b0;
    step(8);  chk("t6_ignore", 3'd1, 1'b0, 2'd0);
    step(1);  chk("t6_rst", 3'd2, 1'b0, 2'd0);
    enable = 1'b0; step(1); chk("t6_abort", 3'd0, 1'b0, 2'd0);
    enable = 1'b1; step(11); chk("t6_rst2", 3'd2, 1'b0, 2'd0);
    step(5);  chk("t6_boot", 3'd3, 1'b0, 2'd0);
    step(3);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_rst", 3'd0, 1'b0, 2'd0);
    step(1);  chk("t6_rst_held", 3'd0, 1'b0, 2'd0);
    rst_n = 1'b1; step(1); chk("t6_restart", 3'd1, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
